// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block-transfer memory port between
// the instruction-side cache controller (port 0) and the data cache (port 1).
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic              p0_ack_o,
  output logic [DATA_W-1:0] p0_data_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic              p1_ack_o,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [1:0]        grant_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              req;
  logic              pick;
  logic              busy;

  assign req  = p0_enable_i | p1_enable_i;
  // On a tie the port not served last wins; otherwise the sole requester.
  assign pick = (p0_enable_i & p1_enable_i) ? ~last_q : p1_enable_i;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    write_d = write_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = BUSY;
          owner_d = pick;
          last_d  = pick;
          write_d = pick ? p1_write_i : p0_write_i;
          addr_d  = pick ? p1_addr_i  : p0_addr_i;
          data_d  = pick ? p1_data_i  : p0_data_i;
        end
      end
      BUSY: begin
        if (mem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b1;
      last_q  <= 1'b1;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign busy         = (state_q == BUSY);
  assign mem_enable_o = busy;
  assign mem_write_o  = write_q;
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = data_q;

  // Read data is only routed to the owner of a live transfer, so reset
  // and idle cycles present zero on both ports.
  assign p0_ack_o  = mem_ack_i & busy & ~owner_q;
  assign p1_ack_o  = mem_ack_i & busy &  owner_q;
  assign p0_data_o = (busy & ~owner_q) ? mem_data_i : '0;
  assign p1_data_o = (busy &  owner_q) ? mem_data_i : '0;

  assign grant_o = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single 256-bit off-chip data-memory interface between the instruction-side cache controller (port 0) and the data cache (port 1). It sits between both cache controllers and `Data_Memory`. It accepts one outstanding block transfer at a time and latches the winner's command onto the memory bus. It routes the memory acknowledge and read block back to the winning port only. Round-robin arbitration guarantees neither port starves.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 256, cache-block width

Ports:
- clk_i  in  1  clock; one clock domain for the whole block
- rst_i  in  1  reset, asynchronous, active-high
- p0_enable_i  in  1  port 0 request; held high until p0_ack_o
- p0_write_i  in  1  port 0 write (1) / read (0)
- p0_addr_i  in  ADDR_W  port 0 block address
- p0_data_i  in  DATA_W  port 0 write block
- p0_ack_o  out  1  port 0 transfer complete, one-cycle pulse
- p0_data_o  out  DATA_W  port 0 read block, valid with p0_ack_o
- p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_ack_o, p1_data_o: same as port 0, for port 1
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  memory write
- mem_addr_o  out  ADDR_W  memory address
- mem_data_o  out  DATA_W  memory write block
- mem_data_i  in  DATA_W  memory read block
- mem_ack_i  in  1  memory done, one-cycle pulse
- grant_o  out  2  one-hot current owner ({p1,p0}); 2'b00 when idle

## Operation
- State machine: IDLE, BUSY.
- Register `owner` (1 bit) holds the current owner. Register `last` (1 bit) holds the last served port. Both reset to 1, so port 0 wins the first tie.

IDLE:
- If exactly one pN_enable_i is high, grant that port.
- If both are high, grant port !last.
- On grant:
  - Latch the winner's write/addr/data into mem_write_o, mem_addr_o and mem_data_o.
  - Set mem_enable_o=1, owner=winner, last=winner.
  - Go to BUSY.
- If neither is high, stay in IDLE.

BUSY:
- Hold all mem_* outputs constant.
- Ignore both pN_enable_i inputs. Changes on the owner's command inputs are not observed.
- On mem_ack_i:
  - Pulse p[owner]_ack_o for that same cycle.
  - Drive p[owner]_data_o = mem_data_i in that same cycle.
  - At the clock edge, set mem_enable_o=0 and return to IDLE.

Output routing:
- pN_ack_o = mem_ack_i & BUSY & (owner==N). This is combinational.
- pN_data_o = mem_data_i when (owner==N), else 0.
- The non-owner never sees ack.

Other rules:
- mem_ack_i while in IDLE is stray. Drop it; no port acks.
- A requester drops pN_enable_i on the edge ending its ack cycle. The arbiter samples enables again in the following IDLE cycle.
- grant_o = BUSY ? (owner ? 2'b10 : 2'b01) : 2'b00.

## Timing
- Reset, asynchronous and immediate. It forces:
  - state=IDLE, owner=1, last=1
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0
  - grant_o=0, both acks=0, both data outputs=0
- Reset during BUSY abandons the transfer. A later mem_ack_i from that transfer arrives in IDLE and is dropped.
- Grant latency: a request sampled high in IDLE at edge N gives mem_enable_o=1 and valid command from cycle N+1.
- Completion: if mem_ack_i is high in cycle M, pN_ack_o is high in cycle M (zero added latency). mem_enable_o is low from M+1.
- Back-to-back: after the ack cycle, IDLE lasts exactly one cycle before the next grant. Minimum gap between transfers is therefore 1 idle cycle.
- Simultaneous requests in IDLE: alternate strictly. A continuously requesting pair is served p0, p1, p0, p1, ...
- A new request arriving during BUSY waits. It is granted no earlier than the IDLE cycle after the current ack.

## Test plan
- Single read on port 0:
  - Stimulus: p0 read addr 0x0000_0400; memory acks 10 cycles after mem_enable_o rises with data 0xA5…A5.
  - Required: p0_ack_o pulses once, p0_data_o=0xA5…A5, p1_ack_o stays 0, grant_o=01 for the whole transfer.
- Tie break from reset:
  - Stimulus: both ports request in the same cycle.
  - Required: port 0 granted first. Port 1 is granted exactly 1 cycle after p0's ack, with mem_addr_o switching to p1_addr_i.
- Fairness:
  - Stimulus: both ports re-request immediately after each ack, for 6 transfers.
  - Required: grant sequence 01,10,01,10,01,10.
- Write pass-through and stability:
  - Stimulus: p1 write addr 0x0000_0800 with data 0x1234…; while BUSY, change p1_addr_i and p1_data_i.
  - Required: mem_write_o=1, and mem_addr_o/mem_data_o keep the latched values until ack.
- Stray ack:
  - Stimulus: pulse mem_ack_i while IDLE with no requests.
  - Required: both acks stay 0 and the state stays IDLE.
- Reset mid-transfer:
  - Stimulus: assert rst_i 3 cycles into a p0 read, release it, then deliver mem_ack_i.
  - Required: all outputs are 0 immediately on reset, and no ack reaches either port.
